// File: rtl/spi_regfile_peripheral_pkg.sv
// rtl/spi_regfile_peripheral_pkg.sv - shared types and helpers for the SPI register-file target
package spi_regfile_peripheral_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    DATA,
    WAIT,
    COMMIT
  } state_t;

  localparam logic RW_WRITE = 1'b1;

  function automatic int frame_w(input int addr_w, input int data_w);
    return 1 + addr_w + data_w;
  endfunction

endpackage

// File: rtl/spi_regfile_peripheral_if.sv
// rtl/spi_regfile_peripheral_if.sv - SPI mode-0 bus between controller (master) and target (slave)
interface spi_regfile_peripheral_if;
  logic sclk;
  logic ncs;
  logic copi;
  logic cipo;
  logic cipo_oe;

  modport master (
    output sclk,
    output ncs,
    output copi,
    input  cipo,
    input  cipo_oe
  );

  modport slave (
    input  sclk,
    input  ncs,
    input  copi,
    output cipo,
    output cipo_oe
  );
endinterface

// File: rtl/spi_regfile_peripheral_sync_edge.sv
// rtl/spi_regfile_peripheral_sync_edge.sv - async input synchroniser with level and edge outputs
module spi_regfile_peripheral_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] ff;
  logic                   hist;

  // Resetting to 0 means a chip select already low at reset release produces no fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff   <= '0;
      hist <= 1'b0;
    end else begin
      ff   <= {ff[SYNC_STAGES-2:0], d};
      hist <= ff[SYNC_STAGES-1];
    end
  end

  assign level = ff[SYNC_STAGES-1];
  assign rise  = level & ~hist;
  assign fall  = ~level & hist;

endmodule

// File: rtl/spi_regfile_peripheral.sv
// rtl/spi_regfile_peripheral.sv - SPI mode-0 target with R/W access to a small register file
module spi_regfile_peripheral
  import spi_regfile_peripheral_pkg::*;
#(
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 8,
  parameter int NUM_REGS    = 5,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  spi_regfile_peripheral_if.slave    spi,
  output logic [NUM_REGS*DATA_W-1:0] regs_q,
  output logic                       wr_stb,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic                       frame_err
);

  localparam int FRAME_W = frame_w(ADDR_W, DATA_W);
  localparam int HDR_W   = 1 + ADDR_W;
  localparam int CNT_W   = $clog2(FRAME_W + 1);
  localparam logic [CNT_W-1:0] HDR_LAST   = CNT_W'(HDR_W - 1);
  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_W - 1);

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic ncs_lvl, ncs_rise, ncs_fall;
  logic copi_lvl, copi_rise, copi_fall;
  logic unused_sync;

  spi_regfile_peripheral_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .d(spi.sclk),
    .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_regfile_peripheral_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ncs (
    .clk(clk), .rst_n(rst_n), .d(spi.ncs),
    .level(ncs_lvl), .rise(ncs_rise), .fall(ncs_fall)
  );

  spi_regfile_peripheral_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_copi (
    .clk(clk), .rst_n(rst_n), .d(spi.copi),
    .level(copi_lvl), .rise(copi_rise), .fall(copi_fall)
  );

  assign unused_sync = sclk_lvl | copi_rise | copi_fall;

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     cnt;
  logic [FRAME_W-1:0]   sh;
  logic [DATA_W-1:0]    out_sh;
  logic                 cipo_q;
  logic                 rd_frame;
  logic                 load_pend;
  logic                 bad;
  logic [DATA_W-1:0]    regs [NUM_REGS];

  logic frame_start, sample, hdr_last, shift_out, late_edge, short_frame, commit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // ncs rise is checked first everywhere so a coincident sclk edge is dropped.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (ncs_fall) state_nxt = HDR;
      HDR: begin
        if (ncs_rise)                           state_nxt = IDLE;
        else if (sclk_rise && cnt == HDR_LAST)  state_nxt = DATA;
      end
      DATA: begin
        if (ncs_rise)                            state_nxt = IDLE;
        else if (sclk_rise && cnt == FRAME_LAST) state_nxt = WAIT;
      end
      WAIT:    if (ncs_rise) state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    frame_start = 1'b0;
    sample      = 1'b0;
    hdr_last    = 1'b0;
    shift_out   = 1'b0;
    late_edge   = 1'b0;
    short_frame = 1'b0;
    commit      = 1'b0;
    unique case (state)
      IDLE: frame_start = ncs_fall;
      HDR, DATA: begin
        short_frame = ncs_rise;
        sample      = sclk_rise & ~ncs_rise;
        hdr_last    = (state == HDR) & sclk_rise & ~ncs_rise & (cnt == HDR_LAST);
        shift_out   = (state == DATA) & sclk_fall & ~ncs_rise & rd_frame;
      end
      WAIT:    late_edge = sclk_rise & ~ncs_rise;
      COMMIT:  commit = 1'b1;
      default: ;
    endcase
  end

  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_value;
  logic              commit_rw;
  logic [ADDR_W-1:0] commit_addr;
  logic [DATA_W-1:0] commit_data;
  logic              addr_ok;

  assign rd_addr     = sh[ADDR_W-1:0];
  assign commit_rw   = sh[FRAME_W-1];
  assign commit_addr = sh[FRAME_W-2 -: ADDR_W];
  assign commit_data = sh[DATA_W-1:0];
  assign addr_ok     = int'(commit_addr) < NUM_REGS;

  // Unimplemented addresses read back as zero.
  always_comb begin
    rd_value = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (int'(rd_addr) == k) rd_value = regs[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      sh        <= '0;
      out_sh    <= '0;
      cipo_q    <= 1'b0;
      rd_frame  <= 1'b0;
      load_pend <= 1'b0;
      bad       <= 1'b0;
      frame_err <= 1'b0;
      wr_stb    <= 1'b0;
      wr_addr   <= '0;
      for (int k = 0; k < NUM_REGS; k++) regs[k] <= '0;
    end else begin
      wr_stb    <= 1'b0;
      load_pend <= hdr_last;
      if (frame_start) begin
        cnt      <= '0;
        sh       <= '0;
        out_sh   <= '0;
        cipo_q   <= 1'b0;
        rd_frame <= 1'b0;
        bad      <= 1'b0;
      end
      if (sample) begin
        sh  <= {sh[FRAME_W-2:0], copi_lvl};
        cnt <= cnt + 1'b1;
      end
      if (load_pend && sh[HDR_W-1] != RW_WRITE) begin
        out_sh   <= rd_value;
        rd_frame <= 1'b1;
      end
      if (shift_out) begin
        cipo_q <= out_sh[DATA_W-1];
        out_sh <= {out_sh[DATA_W-2:0], 1'b0};
      end
      if (late_edge) bad <= 1'b1;
      if (short_frame) begin
        frame_err <= 1'b1;
        rd_frame  <= 1'b0;
      end
      if (commit) begin
        rd_frame  <= 1'b0;
        frame_err <= bad;
        if (!bad && commit_rw == RW_WRITE && addr_ok) begin
          wr_stb  <= 1'b1;
          wr_addr <= commit_addr;
          for (int k = 0; k < NUM_REGS; k++) begin
            if (int'(commit_addr) == k) regs[k] <= commit_data;
          end
        end
      end
    end
  end

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_regs_q
    assign regs_q[k*DATA_W +: DATA_W] = regs[k];
  end

  logic oe;
  assign oe          = rd_frame & ~ncs_lvl;
  assign spi.cipo_oe = oe;
  assign spi.cipo    = oe & cipo_q;

endmodule

// File: tb/tb_spi_regfile_peripheral.sv
// tb/tb_spi_regfile_peripheral.sv - scoreboard bench for the SPI register-file target
module tb_spi_regfile_peripheral;

  logic        clk;
  logic        rst_n;
  logic [39:0] regs_q;
  logic        wr_stb;
  logic [6:0]  wr_addr;
  logic        frame_err;

  int checks   = 0;
  int failures = 0;
  bit mon_en   = 0;

  typedef struct {
    logic [6:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t        exp_wr[$];
  logic [7:0] exp_rd[$];
  logic [7:0] rd_bits = '0;
  int         rd_n    = 0;

  spi_regfile_peripheral_if spi ();

  spi_regfile_peripheral #(
    .ADDR_W(7), .DATA_W(8), .NUM_REGS(5), .SYNC_STAGES(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .spi(spi.slave),
    .regs_q(regs_q),
    .wr_stb(wr_stb),
    .wr_addr(wr_addr),
    .frame_err(frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bits(input logic [31:0] v, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) begin
      spi.copi = v[i];
      clks(5);
      spi.sclk = 1'b1;
      clks(5);
      spi.sclk = 1'b0;
    end
  endtask

  task automatic frame(input logic [31:0] v, input int n, input int gap);
    spi.ncs = 1'b0;
    clks(5);
    send_bits(v, n - 1, 0);
    clks(5);
    spi.ncs = 1'b1;
    clks(gap);
  endtask

  task automatic wr(input logic [6:0] a, input logic [7:0] d, input bit stb, input int gap);
    wr_t e;
    e.addr = a;
    e.data = d;
    if (stb) exp_wr.push_back(e);
    frame({16'h0, 1'b1, a, d}, 16, gap);
  endtask

  task automatic rd(input logic [6:0] a, input logic [7:0] exp);
    exp_rd.push_back(exp);
    frame({16'h0, 1'b0, a, 8'h00}, 16, 8);
  endtask

  task automatic chk_state(input string name, input logic [39:0] r, input logic e);
    chk({name, "_regs"}, 64'(regs_q), 64'(r));
    chk({name, "_err"}, 64'(frame_err), 64'(e));
  endtask

  // Write monitor: every strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (mon_en && wr_stb === 1'b1) begin
      if (exp_wr.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_wr_stb wr_addr=%0h required=no_strobe", wr_addr);
      end else begin
        wr_t e;
        e = exp_wr.pop_front();
        chk("wr_addr", 64'(wr_addr), 64'(e.addr));
        chk("wr_data", 64'(regs_q[int'(e.addr)*8 +: 8]), 64'(e.data));
      end
    end
  end

  always @(posedge spi.sclk) begin
    if (spi.cipo_oe === 1'b1) begin
      rd_bits = {rd_bits[6:0], spi.cipo};
      rd_n++;
    end
  end

  // Read monitor: a read frame ends when cipo_oe drops.
  always @(negedge spi.cipo_oe) begin
    if (mon_en) begin
      if (exp_rd.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_read data=%0h required=no_read", rd_bits);
      end else begin
        chk("rd_data", 64'(rd_bits), 64'(exp_rd.pop_front()));
        chk("rd_bits", 64'(rd_n), 64'd8);
      end
      rd_bits = '0;
      rd_n    = 0;
    end
  end

  initial begin
    rst_n    = 1'b0;
    spi.sclk = 1'b0;
    spi.ncs  = 1'b1;
    spi.copi = 1'b0;
    clks(5);
    chk_state("reset", 40'h0, 1'b0);
    chk("reset_wr_stb", 64'(wr_stb), 64'd0);
    chk("reset_wr_addr", 64'(wr_addr), 64'd0);
    chk("reset_cipo_oe", 64'(spi.cipo_oe), 64'd0);
    chk("reset_cipo", 64'(spi.cipo), 64'd0);
    rst_n = 1'b1;
    clks(5);
    mon_en = 1;

    wr(7'h02, 8'hA5, 1, 8);
    chk_state("t1", 40'h00_00_A5_00_00, 1'b0);

    wr(7'h04, 8'h3C, 1, 8);
    rd(7'h04, 8'h3C);
    chk_state("t2", 40'h3C_00_A5_00_00, 1'b0);

    wr(7'h10, 8'hFF, 0, 8);
    chk_state("t3_wr", 40'h3C_00_A5_00_00, 1'b0);
    rd(7'h10, 8'h00);
    chk_state("t3_rd", 40'h3C_00_A5_00_00, 1'b0);

    frame(32'h0000_081F, 12, 8);
    chk_state("t4_short", 40'h3C_00_A5_00_00, 1'b1);
    frame(32'h0001_00AB, 17, 8);
    chk_state("t4_long", 40'h3C_00_A5_00_00, 1'b1);
    wr(7'h01, 8'h77, 1, 8);
    chk_state("t4_clear", 40'h3C_00_A5_77_00, 1'b0);

    frame(32'h0000_0015, 5, 8);
    chk("t5_pre_err", 64'(frame_err), 64'd1);
    spi.ncs = 1'b0;
    clks(5);
    send_bits(32'h0000_8199, 15, 7);
    rst_n = 1'b0;
    clks(2);
    chk_state("t5_rst", 40'h0, 1'b0);
    chk("t5_rst_wr_addr", 64'(wr_addr), 64'd0);
    chk("t5_rst_cipo_oe", 64'(spi.cipo_oe), 64'd0);
    rst_n = 1'b1;
    send_bits(32'h0000_8199, 6, 0);
    clks(5);
    spi.ncs = 1'b1;
    clks(10);
    chk_state("t5_no_commit", 40'h0, 1'b0);
    wr(7'h01, 8'h99, 1, 8);
    chk_state("t5_after", 40'h00_00_00_99_00, 1'b0);

    wr(7'h00, 8'h11, 1, 2);
    wr(7'h03, 8'h22, 1, 8);
    chk_state("t6", 40'h00_22_00_99_11, 1'b0);

    clks(20);
    chk("wr_queue_drained", 64'(exp_wr.size()), 64'd0);
    chk("rd_queue_drained", 64'(exp_rd.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
